// File: rtl/tlul_periph_demux_pkg.sv
// TL-UL types, opcodes and the peripheral address map shared by the demux and its sub-modules.
package tlul_periph_demux_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Peripheral map used by the SoC top: four 4 KiB windows starting at 0x4000_0000.
  localparam int unsigned NumPeriph = 4;
  localparam logic [NumPeriph-1:0][31:0] PeriphAddrBase = {
    32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000
  };
  localparam logic [NumPeriph-1:0][31:0] PeriphAddrMask = {
    32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF
  };

  // Address matches a window when every non-masked bit equals the base.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/tlul_periph_demux_err.sv
// One-deep TL-UL error responder: answers any accepted request with d_error=1.
import tlul_periph_demux_pkg::*;

module tlul_err_resp (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  typedef enum logic {
    ErrIdle,
    ErrResp
  } err_state_e;

  err_state_e  state_q, state_d;
  tl_a_op_e    op_q, op_d;
  logic [7:0]  src_q, src_d;
  logic [1:0]  size_q, size_d;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address, tl_i.a_mask, tl_i.a_data};

  // State and captured request fields
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ErrIdle;
      op_q    <= PutFullData;
      src_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      size_q  <= size_d;
    end
  end

  // Accept one request when idle, then hold the error response until d_ready
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    size_d  = size_q;
    tl_o    = '0;
    unique case (state_q)
      ErrIdle: begin
        tl_o.a_ready = 1'b1;
        if (tl_i.a_valid) begin
          op_d    = tl_i.a_opcode;
          src_d   = tl_i.a_source;
          size_d  = tl_i.a_size;
          state_d = ErrResp;
        end
      end
      ErrResp: begin
        tl_o.d_valid  = 1'b1;
        tl_o.d_error  = 1'b1;
        tl_o.d_data   = '1;
        tl_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
        tl_o.d_source = src_q;
        tl_o.d_size   = size_q;
        if (tl_i.d_ready) state_d = ErrIdle;
      end
      default: state_d = ErrIdle;
    endcase
  end

endmodule

// File: rtl/tlul_periph_demux.sv
// 1-host to NumDev-device TL-UL demux with in-order outstanding tracking and an error sink.
import tlul_periph_demux_pkg::*;

module tlul_periph_demux #(
  parameter int unsigned                 NumDev         = NumPeriph,
  parameter int unsigned                 MaxOutstanding = 4,
  parameter logic [NumDev-1:0][31:0]     AddrBase       = PeriphAddrBase,
  parameter logic [NumDev-1:0][31:0]     AddrMask       = PeriphAddrMask
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o,
  output tl_h2d_t tl_d_o [NumDev],
  input  tl_d2h_t tl_d_i [NumDev]
);

  localparam int unsigned IdxW = $clog2(NumDev + 1);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [IdxW-1:0] ErrIdx = IdxW'(NumDev);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [IdxW-1:0] idx;
  logic [IdxW-1:0] dev_q, dev_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stall;
  logic            sel_a_ready;
  logic            a_ready;
  logic            a_acc;
  logic            d_hs;
  logic            err_vld;
  logic            stray_dvalid;
  tl_d2h_t         d_sel;
  tl_h2d_t         err_tl_i;
  tl_d2h_t         err_tl_o;

  assign err_vld = err_tl_o.d_valid;

  // Address decode: lowest matching window wins, no match selects the error sink
  always_comb begin
    logic hit;
    hit = 1'b0;
    idx = ErrIdx;
    for (int unsigned i = 0; i < NumDev; i++) begin
      if (!hit && addr_hit(tl_h_i.a_address, AddrBase[i], AddrMask[i])) begin
        hit = 1'b1;
        idx = IdxW'(i);
      end
    end
  end

  // Stall on device switch, full outstanding window, or busy error responder
  always_comb begin
    stall = ((cnt_q != '0) && (idx != dev_q)) || (cnt_q == CntMax) ||
            ((idx == ErrIdx) && err_vld);
  end

  // Request fan-out and response-ready steering
  always_comb begin
    sel_a_ready = err_tl_o.a_ready;
    for (int unsigned i = 0; i < NumDev; i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = tl_h_i.a_valid & ~stall & (idx == IdxW'(i));
      tl_d_o[i].d_ready = tl_h_i.d_ready & (dev_q == IdxW'(i));
      if (idx == IdxW'(i)) sel_a_ready = tl_d_i[i].a_ready;
    end
    err_tl_i         = tl_h_i;
    err_tl_i.a_valid = tl_h_i.a_valid & ~stall & (idx == ErrIdx);
    err_tl_i.d_ready = tl_h_i.d_ready & (dev_q == ErrIdx);
    a_ready          = ~stall & sel_a_ready;
  end

  // Response path follows the device that owns the in-flight requests
  always_comb begin
    d_sel        = err_tl_o;
    stray_dvalid = 1'b0;
    for (int unsigned i = 0; i < NumDev; i++) begin
      if (dev_q == IdxW'(i)) d_sel = tl_d_i[i];
      else if (tl_d_i[i].d_valid) stray_dvalid = 1'b1;
    end
    tl_h_o         = d_sel;
    tl_h_o.a_ready = a_ready;
  end

  // Outstanding counter and owning-device tracking
  always_comb begin
    a_acc = tl_h_i.a_valid & a_ready;
    d_hs  = d_sel.d_valid & tl_h_i.d_ready;
    dev_d = a_acc ? idx : dev_q;
    cnt_d = cnt_q;
    unique case ({a_acc, d_hs})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter and device registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      dev_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dev_q <= dev_d;
    end
  end

  tlul_err_resp u_err_resp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_i   (err_tl_i),
    .tl_o   (err_tl_o)
  );

  a_no_d_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    d_hs |-> (cnt_q != '0));
  a_no_stray_dvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !stray_dvalid);

endmodule

// File: tb/tb_tlul_periph_demux.sv
// Scoreboard bench for tlul_periph_demux: directed requests, queued expected responses.
module tb_tlul_periph_demux;
  import tlul_periph_demux_pkg::*;

  localparam int unsigned NDEV = 4;

  typedef struct packed {
    tl_d_op_e    op;
    logic [7:0]  src;
    logic [1:0]  size;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic    clk_i = 1'b0;
  logic    rst_ni;
  tl_h2d_t tl_h_i;
  tl_d2h_t tl_h_o;
  tl_h2d_t tl_d_o [NDEV];
  tl_d2h_t tl_d_i [NDEV];

  logic hold [NDEV];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   max_cnt  = 0;
  rsp_t exp_q[$];

  tlul_periph_demux #(
    .NumDev         (NDEV),
    .MaxOutstanding (4),
    .AddrBase       (PeriphAddrBase),
    .AddrMask       (PeriphAddrMask)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_h_i (tl_h_i),
    .tl_h_o (tl_h_o),
    .tl_d_o (tl_d_o),
    .tl_d_i (tl_d_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic rsp_t mk(input tl_d_op_e op, input logic [7:0] src,
                              input logic [31:0] data, input logic err);
    rsp_t r;
    r.op = op; r.src = src; r.size = 2'd2; r.data = data; r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Device models: queue accepted requests, answer in order unless held off
  initial begin
    logic [2:0] dq_op   [NDEV][16];
    logic [7:0] dq_src  [NDEV][16];
    logic [1:0] dq_size [NDEV][16];
    logic [3:0] wp [NDEV];
    logic [3:0] rp [NDEV];
    logic       acc [NDEV];
    logic       hs  [NDEV];
    logic [2:0] c_op   [NDEV];
    logic [7:0] c_src  [NDEV];
    logic [1:0] c_size [NDEV];
    for (int i = 0; i < NDEV; i++) begin
      wp[i] = '0; rp[i] = '0; hold[i] = 1'b0;
      tl_d_i[i] = '0;
      tl_d_i[i].a_ready = 1'b1;
    end
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < NDEV; i++) begin
        acc[i]    = tl_d_o[i].a_valid && tl_d_i[i].a_ready;
        hs[i]     = tl_d_i[i].d_valid && tl_d_o[i].d_ready;
        c_op[i]   = tl_d_o[i].a_opcode;
        c_src[i]  = tl_d_o[i].a_source;
        c_size[i] = tl_d_o[i].a_size;
      end
      @(posedge clk_i);
      #2;
      for (int i = 0; i < NDEV; i++) begin
        if (rst_ni !== 1'b1) begin
          wp[i] = '0; rp[i] = '0;
        end else begin
          if (hs[i]) rp[i] = rp[i] + 4'd1;
          if (acc[i]) begin
            dq_op[i][wp[i]] = c_op[i]; dq_src[i][wp[i]] = c_src[i]; dq_size[i][wp[i]] = c_size[i];
            wp[i] = wp[i] + 4'd1;
          end
        end
        tl_d_i[i] = '0;
        tl_d_i[i].a_ready = 1'b1;
        if (wp[i] != rp[i] && !hold[i]) begin
          tl_d_i[i].d_valid  = 1'b1;
          tl_d_i[i].d_opcode = (dq_op[i][rp[i]] == Get) ? AccessAckData : AccessAck;
          tl_d_i[i].d_source = dq_src[i][rp[i]];
          tl_d_i[i].d_size   = dq_size[i][rp[i]];
          tl_d_i[i].d_data   = (dq_op[i][rp[i]] == Get) ? 32'h1234 + 32'(i) * 32'h1111 : 32'h0;
        end
      end
    end
  end

  // Monitor: every host D handshake pops and compares one expected response
  initial begin
    rsp_t act, e;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1) begin
        if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
        if (tl_h_o.d_valid && tl_h_i.d_ready) begin
          act.op = tl_h_o.d_opcode; act.src = tl_h_o.d_source; act.size = tl_h_o.d_size;
          act.data = tl_h_o.d_data; act.err = tl_h_o.d_error;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL d_unexpected: got %h, expected no response", act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              n_fail++;
              $display("FAIL d_response: got %h, expected %h", act, e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic [31:0] addr, input tl_a_op_e op, input logic [7:0] src);
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = op;
    tl_h_i.a_param   = '0;
    tl_h_i.a_size    = 2'd2;
    tl_h_i.a_source  = src;
    tl_h_i.a_address = addr;
    tl_h_i.a_mask    = '1;
    tl_h_i.a_data    = addr ^ 32'h5A5A_0000;
  endtask

  task automatic wait_accept(input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk_i);
      if (tl_h_o.a_ready) ok = 1'b1;
      tick();
    end
    tl_h_i.a_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no a_ready, expected accept within 20 cycles", name);
    end
  endtask

  task automatic send(input logic [31:0] addr, input tl_a_op_e op, input logic [7:0] src,
                      input logic push, input rsp_t e);
    if (push) exp_q.push_back(e);
    drive_a(addr, op, src);
    wait_accept("accept");
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tl_h_i = '0;
    tl_h_i.d_ready = 1'b1;
    rst_ni = 1'b0;
    repeat (3) tick();
    check("rst_cnt", dut.cnt_q, 0);
    check("rst_dvalid", tl_h_o.d_valid, 0);
    check("rst_dev0_avalid", tl_d_o[0].a_valid, 0);
    rst_ni = 1'b1;
    tick();

    // Simple read from dev0
    send(32'h4000_0004, Get, 8'd1, 1'b1, mk(AccessAckData, 8'd1, 32'h1234, 1'b0));
    check("t1_cnt_accept", dut.cnt_q, 1);
    tick();
    check("t1_cnt_resp", dut.cnt_q, 0);
    wait_drain("t1_drain");

    // Four Puts to dev1 with responses held: fifth request stalls
    hold[1] = 1'b1;
    for (int k = 0; k < 4; k++)
      send(32'h4000_1000 + 32'(4 * k), PutFullData, 8'(8 + k), 1'b1,
           mk(AccessAck, 8'(8 + k), 32'h0, 1'b0));
    check("t2_cnt_full", dut.cnt_q, 4);
    exp_q.push_back(mk(AccessAck, 8'd12, 32'h0, 1'b0));
    drive_a(32'h4000_1010, PutFullData, 8'd12);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t2_stall", tl_h_o.a_ready, 0);
      tick();
    end
    hold[1] = 1'b0;
    @(negedge clk_i);
    check("t2_stall_hs_cycle", tl_h_o.a_ready, 0);
    check("t2_dvalid", tl_h_o.d_valid, 1);
    tick();
    check("t2_cnt_after_hs", dut.cnt_q, 3);
    wait_accept("t2_fifth");
    wait_drain("t2_drain");

    // Device switch waits for the old device to drain
    hold[0] = 1'b1;
    send(32'h4000_0010, PutFullData, 8'd5, 1'b1, mk(AccessAck, 8'd5, 32'h0, 1'b0));
    exp_q.push_back(mk(AccessAckData, 8'd6, 32'h3456, 1'b0));
    drive_a(32'h4000_2004, Get, 8'd6);
    @(negedge clk_i);
    check("t3_stall", tl_h_o.a_ready, 0);
    check("t3_dev2_avalid_0", tl_d_o[2].a_valid, 0);
    tick();
    hold[0] = 1'b0;
    @(negedge clk_i);
    check("t3_dev2_avalid_hs", tl_d_o[2].a_valid, 0);
    check("t3_dev0_dvalid", tl_h_o.d_valid, 1);
    tick();
    @(negedge clk_i);
    check("t3_dev2_avalid_1", tl_d_o[2].a_valid, 1);
    check("t3_aready", tl_h_o.a_ready, 1);
    tick();
    tl_h_i.a_valid = 1'b0;
    check("t3_cnt", dut.cnt_q, 1);
    wait_drain("t3_drain");

    // Unmapped accesses: error response and one-cycle bubble
    send(32'hDEAD_0000, Get, 8'd3, 1'b1, mk(AccessAckData, 8'd3, 32'hFFFF_FFFF, 1'b1));
    exp_q.push_back(mk(AccessAck, 8'd4, 32'hFFFF_FFFF, 1'b1));
    drive_a(32'hDEAD_0100, PutFullData, 8'd4);
    @(negedge clk_i);
    check("t4_err_dvalid", tl_h_o.d_valid, 1);
    check("t4_bubble", tl_h_o.a_ready, 0);
    tick();
    wait_accept("t4_second");
    tl_h_i.d_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t4_dvalid_hold", tl_h_o.d_valid, 1);
      tick();
    end
    tl_h_i.d_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_cnt", dut.cnt_q, 0);

    // Accept and D handshake in the same cycle leave the count unchanged
    hold[3] = 1'b1;
    send(32'h4000_3000, Get, 8'd20, 1'b1, mk(AccessAckData, 8'd20, 32'h4567, 1'b0));
    send(32'h4000_3004, Get, 8'd21, 1'b1, mk(AccessAckData, 8'd21, 32'h4567, 1'b0));
    check("t5_cnt_pre", dut.cnt_q, 2);
    exp_q.push_back(mk(AccessAckData, 8'd22, 32'h4567, 1'b0));
    hold[3] = 1'b0;
    drive_a(32'h4000_3008, Get, 8'd22);
    @(negedge clk_i);
    check("t5_dvalid", tl_h_o.d_valid, 1);
    check("t5_aready", tl_h_o.a_ready, 1);
    tick();
    tl_h_i.a_valid = 1'b0;
    check("t5_cnt_same", dut.cnt_q, 2);
    wait_drain("t5_drain");

    // Reset mid-burst drops everything in flight
    tl_h_i.d_ready = 1'b0;
    hold[1] = 1'b1;
    for (int k = 0; k < 3; k++)
      send(32'h4000_1000, PutFullData, 8'(30 + k), 1'b0, mk(AccessAck, 8'd0, 32'h0, 1'b0));
    check("t6_cnt_pre", dut.cnt_q, 3);
    hold[1] = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_cnt_rst", dut.cnt_q, 0);
    check("t6_devq_rst", dut.dev_q, 0);
    check("t6_dvalid_rst", tl_h_o.d_valid, 0);
    check("t6_dev1_avalid", tl_d_o[1].a_valid, 0);
    exp_q.delete();
    repeat (2) tick();
    tl_h_i.d_ready = 1'b1;
    rst_ni = 1'b1;
    exp_q.push_back(mk(AccessAckData, 8'd40, 32'h4567, 1'b0));
    drive_a(32'h4000_3010, Get, 8'd40);
    @(negedge clk_i);
    check("t6_first_accept", tl_h_o.a_ready, 1);
    tick();
    tl_h_i.a_valid = 1'b0;
    wait_drain("t6_drain");

    check("max_cnt", max_cnt, 4);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
